mux_sel_seq: RTL and testbench
==============================

MUX_SEL_SEQ -- requirements
Module: mux_sel_seq

Interface
REQ-001 Parameter DWELL_W, default 8, width of the dwell-period operand and dwell counter.
REQ-002 Parameter CNT_W, default 8, width of the toggle-count operand and toggle counter.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  request a select sequence, sampled only in IDLE.
REQ-006 stop  input  1  abort the running sequence, sampled every cycle.
REQ-007 dwell  input  DWELL_W  cycles each select value is held, latched on accepted start.
REQ-008 n_toggles  input  CNT_W  number of select toggles to perform, latched on accepted start.
REQ-009 x  output  1  select line for the downstream 1-bit mux (x=1 selects a, x=0 selects b).
REQ-010 busy  output  1  high while the sequence is running.
REQ-011 done  output  1  one-cycle pulse on normal completion.
REQ-012 toggle_cnt  output  CNT_W  toggles performed in the current or last sequence.

Function
REQ-013 FSM states SHALL be IDLE, RUN, DONE.
REQ-014 IDLE: x=0, busy=0, done=0; start=1 and stop=0 at edge cycle 0 -> RUN from cycle 1, latch dwell/n_toggles, clear toggle_cnt.
REQ-015 Latched dwell of 0 SHALL be treated as 1.
REQ-016 RUN: busy=1; x SHALL toggle at the end of each dwell-cycle period, first change visible in cycle 1+dwell, toggle_cnt increments with each toggle.
REQ-017 After the N-th toggle (N=n_toggles), x SHALL hold one further dwell period, then enter DONE in cycle 1+(N+1)*dwell.
REQ-018 DONE: lasts exactly one cycle, done=1, busy=0, x holds last value; next cycle IDLE with x=0.
REQ-019 N=0 (without config macro): x stays 0 for dwell cycles, then DONE in cycle 1+dwell, toggle_cnt=0.
REQ-020 start while in RUN or DONE SHALL be ignored, latched operands unchanged.
REQ-021 stop=1 in RUN SHALL force IDLE next cycle, x=0, busy=0, no done pulse; toggle_cnt holds its value.
REQ-022 stop and start both high in IDLE: stop wins, remain IDLE.
REQ-023 stop high in DONE: done pulse still completes, then IDLE.
REQ-024 toggle_cnt SHALL saturate at all-ones, never wrap.
REQ-025 x, busy, done SHALL be driven directly from flops (glitch-free select).

Reset
REQ-026 rst_n low SHALL asynchronously force IDLE, x=0, busy=0, done=0, toggle_cnt=0, dwell/toggle counters 0, including mid-sequence.
REQ-027 First start accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-028 Macro MUX_SEL_SEQ_CONTINUOUS_EN defined: N=0 SHALL mean toggle indefinitely until stop, never entering DONE; toggle_cnt saturates.
REQ-029 Macro undefined: N=0 behaves per REQ-019; all other behaviour identical in both builds.

Structure
REQ-030 Package mux_sel_pkg SHALL hold the state enum (IDLE, RUN, DONE) and default widths DWELL_W_DEF=8, CNT_W_DEF=8.
REQ-031 Sub-module dwell_timer SHALL implement the reloadable dwell down-counter with a one-cycle expire pulse; FSM and toggle logic stay in mux_sel_seq.

Verification
REQ-032 dwell=3, N=2, start in cycle 0 -> busy from cycle 1, x=1 in cycle 4, x=0 in cycle 7, done in cycle 10, toggle_cnt=2.
REQ-033 dwell=0, N=1 -> treated as dwell=1: x=1 in cycle 2, done in cycle 3.
REQ-034 dwell=4, N=5, stop in cycle 6 -> IDLE in cycle 7, x=0, no done, toggle_cnt=1.
REQ-035 N=0, dwell=2: without macro done in cycle 3, x never 1; with MUX_SEL_SEQ_CONTINUOUS_EN x toggles every 2 cycles until stop.
REQ-036 rst_n pulsed low in cycle 5 of a dwell=2, N=4 run -> immediately x=0, busy=0, toggle_cnt=0; new start accepted afterwards.
REQ-037 start re-asserted in cycles 2-8 of a running sequence -> no effect on timing; start+stop together in IDLE -> stays IDLE.

Source files
------------

// File: rtl/mux_sel_pkg.sv
// rtl/mux_sel_pkg.sv - shared types and default widths for the mux select sequencer
//
// Holds the sequencer state encoding and the default operand widths used by
// mux_sel_seq.

package mux_sel_pkg;

  localparam int DWELL_W_DEF = 8;
  localparam int CNT_W_DEF   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/dwell_timer.sv
// rtl/dwell_timer.sv - reloadable dwell down-counter with one-cycle expire pulse
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   load_i     latch period_i (zero treated as one) and restart the count
//   en_i       count enable; counter holds while low
//   period_i   dwell period in cycles
//   expire_o   high in the last cycle of each period while enabled

module dwell_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         en_i,
  input  logic [W-1:0] period_i,
  output logic         expire_o
);

  logic [W-1:0] period_q;
  logic [W-1:0] cnt_q;
  logic [W-1:0] period_eff;

  // A zero dwell would never expire; the shortest meaningful period is one.
  assign period_eff = (period_i == '0) ? W'(1) : period_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_q <= '0;
      cnt_q    <= '0;
    end else if (load_i) begin
      period_q <= period_eff;
      cnt_q    <= period_eff;
    end else if (en_i) begin
      if (cnt_q == W'(1)) begin
        cnt_q <= period_q;
      end else begin
        cnt_q <= cnt_q - W'(1);
      end
    end
  end

  assign expire_o = en_i && (cnt_q == W'(1));

endmodule

// File: rtl/mux_sel_seq.sv
// rtl/mux_sel_seq.sv - timed select-line toggler for a downstream 1-bit mux
//
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   start        begin a sequence (sampled only when idle)
//   stop         abort a running sequence (stop beats start when idle)
//   dwell        cycles each select value is held (0 behaves as 1)
//   n_toggles    number of select toggles to perform
//   x            registered mux select (1 selects a, 0 selects b)
//   busy         registered, high while the sequence runs
//   done         registered one-cycle pulse on normal completion
//   toggle_cnt   toggles performed in the current or last sequence (saturating)
//
// Build option: MUX_SEL_SEQ_CONTINUOUS_EN makes n_toggles=0 toggle
// indefinitely until stop instead of finishing after one dwell period.

module mux_sel_seq
  import mux_sel_pkg::*;
#(
  parameter int DWELL_W = DWELL_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [CNT_W-1:0]   n_toggles,
  output logic               x,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   toggle_cnt
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             x_q, x_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             accept;
  logic             expire;
  logic             last_toggle;

  assign accept = (state_q == IDLE) && start && !stop;

  dwell_timer #(
    .W(DWELL_W)
  ) u_dwell_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (accept),
    .en_i     (state_q == RUN),
    .period_i (dwell),
    .expire_o (expire)
  );

  // The period that expires with all N toggles already made is the final
  // hold period; the sequence then finishes instead of toggling again.
`ifdef MUX_SEL_SEQ_CONTINUOUS_EN
  assign last_toggle = (cnt_q == n_q) && (n_q != '0);
`else
  assign last_toggle = (cnt_q == n_q);
`endif

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    case (state_q)
      IDLE: begin
        x_d = 1'b0;
        if (accept) begin
          state_d = RUN;
          n_d     = n_toggles;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
          x_d     = 1'b0;
        end else if (expire) begin
          if (last_toggle) begin
            state_d = DONE;
          end else begin
            x_d = ~x_q;
            if (cnt_q != '1) begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        x_d     = 1'b0;
      end
      default: begin
        state_d = IDLE;
        x_d     = 1'b0;
      end
    endcase
    // Status flags are registered from the next state so they line up
    // with the state and never glitch.
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      n_q     <= '0;
      cnt_q   <= '0;
      x_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign x          = x_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign toggle_cnt = cnt_q;

endmodule

// File: tb/tb_mux_sel_seq.sv
// tb/tb_mux_sel_seq.sv - self-checking scoreboard bench for mux_sel_seq

module tb_mux_sel_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic [7:0] dwell;
  logic [7:0] n_toggles;
  logic       x;
  logic       busy;
  logic       done;
  logic [7:0] toggle_cnt;

  int total;
  int bad;

`ifdef MUX_SEL_SEQ_CONTINUOUS_EN
  localparam bit CONT = 1'b1;
`else
  localparam bit CONT = 1'b0;
`endif

  typedef struct {
    logic       x;
    logic       busy;
    logic       done;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb[$];

  mux_sel_seq #(
    .DWELL_W(8),
    .CNT_W  (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .dwell      (dwell),
    .n_toggles  (n_toggles),
    .x          (x),
    .busy       (busy),
    .done       (done),
    .toggle_cnt (toggle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int tog_at(int t, int de);
    int k;
    k = (t - 1) / de;
    return (k > 255) ? 255 : k;
  endfunction

  // Expected outputs in cycle c of a run started in cycle 0.
  function automatic exp_t model(int c, int de, int n, int stop_at);
    exp_t e;
    int   dc;
    e.x    = 1'b0;
    e.busy = 1'b0;
    e.done = 1'b0;
    e.cnt  = 8'd0;
    dc = (CONT && n == 0) ? 32'h3fff_ffff : 1 + (n + 1) * de;
    if (stop_at > 0 && stop_at < dc && c > stop_at) begin
      e.cnt = 8'(tog_at(stop_at, de));
    end else if (c < dc) begin
      e.busy = 1'b1;
      e.x    = 1'(((c - 1) / de) & 1);
      e.cnt  = 8'(tog_at(c, de));
    end else if (c == dc) begin
      e.done = 1'b1;
      e.x    = 1'(n & 1);
      e.cnt  = 8'(n);
    end else begin
      e.cnt = 8'(n);
    end
    return e;
  endfunction

  task automatic check_cycle(input string name, input int c);
    exp_t e;
    e = sb.pop_front();
    total++;
    if (x !== e.x) begin
      bad++;
      $display("FAIL %s.x cycle=%0d got=%0b exp=%0b", name, c, x, e.x);
    end
    total++;
    if (busy !== e.busy) begin
      bad++;
      $display("FAIL %s.busy cycle=%0d got=%0b exp=%0b", name, c, busy, e.busy);
    end
    total++;
    if (done !== e.done) begin
      bad++;
      $display("FAIL %s.done cycle=%0d got=%0b exp=%0b", name, c, done, e.done);
    end
    total++;
    if (toggle_cnt !== e.cnt) begin
      bad++;
      $display("FAIL %s.cnt cycle=%0d got=%0d exp=%0d", name, c, toggle_cnt, e.cnt);
    end
  endtask

  // Called with the bench sitting just after a rising edge (cycle 0).
  // rs..re: cycles in which start is re-asserted with different operands.
  task automatic run_seq(input string name, input int d, input int n, input int ncyc,
                         input int stop_at, input int rs, input int re);
    int de;
    de = (d == 0) ? 1 : d;
    for (int c = 1; c <= ncyc; c++) sb.push_back(model(c, de, n, stop_at));
    start     = 1'b1;
    stop      = 1'b0;
    dwell     = 8'(d);
    n_toggles = 8'(n);
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk);
      #1;
      start = (c >= rs && c <= re);
      if (start) begin
        dwell     = 8'd7;
        n_toggles = 8'd9;
      end
      stop = (c == stop_at);
      check_cycle(name, c);
    end
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic test_reset;
    rst_n     = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
    dwell     = 8'd0;
    n_toggles = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    sb.push_back('{x: 1'b0, busy: 1'b0, done: 1'b0, cnt: 8'd0});
    check_cycle("reset", 0);
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    run_seq("basic", 3, 2, 12, 0, 0, 0);
  endtask

  task automatic test_dwell_zero;
    run_seq("dwell0", 0, 1, 5, 0, 0, 0);
  endtask

  task automatic test_stop_run;
    run_seq("stop_run", 4, 5, 9, 6, 0, 0);
  endtask

  task automatic test_zero_n;
    if (CONT) run_seq("zero_n", 2, 0, 10, 7, 0, 0);
    else run_seq("zero_n", 2, 0, 6, 0, 0, 0);
  endtask

  task automatic test_restart_ignored;
    run_seq("restart", 3, 2, 12, 0, 2, 8);
  endtask

  task automatic test_start_stop_idle;
    for (int c = 1; c <= 3; c++) sb.push_back('{x: 1'b0, busy: 1'b0, done: 1'b0, cnt: 8'd2});
    start     = 1'b1;
    stop      = 1'b1;
    dwell     = 8'd1;
    n_toggles = 8'd1;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk);
      #1;
      check_cycle("start_stop_idle", c);
    end
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic test_stop_in_done;
    run_seq("stop_done", 1, 1, 5, 3, 0, 0);
  endtask

  task automatic test_reset_mid_run;
    run_seq("pre_reset", 2, 4, 4, 0, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    sb.push_back('{x: 1'b0, busy: 1'b0, done: 1'b0, cnt: 8'd0});
    check_cycle("mid_reset", 5);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_seq("post_reset", 2, 4, 13, 0, 0, 0);
  endtask

  task automatic test_saturate;
`ifdef MUX_SEL_SEQ_CONTINUOUS_EN
    run_seq("saturate", 1, 0, 262, 260, 0, 0);
`endif
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset;
    test_basic;
    test_dwell_zero;
    test_stop_run;
    test_zero_n;
    test_restart_ignored;
    test_start_stop_idle;
    test_stop_in_done;
    test_reset_mid_run;
    test_saturate;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
